// File: rtl/writeback_unit_if.sv
// Shared writeback types and the memory-stage / register-file bundle.
// The package lives here so the interface and the unit both see it first.
package writeback_pkg;
    localparam int XLEN = 32;

    typedef logic [4:0] rv_reg_t;

    typedef struct packed {
        logic            enable;
        rv_reg_t         which_register;
        logic [XLEN-1:0] value;
    } reg_write_control_t;

    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_ALU  = 2'd1,
        K_LOAD = 2'd2,
        K_RSVD = 2'd3
    } wb_kind_e;
endpackage

interface writeback_unit_if #(
    parameter int CNT_WIDTH = 64
);
    import writeback_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_kind;
    rv_reg_t              in_rd;
    logic [XLEN-1:0]      in_alu_value;
    logic [2:0]           in_funct3;
    logic [1:0]           in_addr_lo;
    logic                 mem_rdata_valid;
    logic [XLEN-1:0]      mem_rdata;
    reg_write_control_t   write_control;
    logic                 pending_load_valid;
    rv_reg_t              pending_load_rd;
    logic                 load_fault;
    logic [CNT_WIDTH-1:0] retired_count;

    modport master (
        output in_valid, in_kind, in_rd, in_alu_value,
        output in_funct3, in_addr_lo,
        output mem_rdata_valid, mem_rdata,
        input  in_ready, write_control,
        input  pending_load_valid, pending_load_rd,
        input  load_fault, retired_count
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_alu_value,
        input  in_funct3, in_addr_lo,
        input  mem_rdata_valid, mem_rdata,
        output in_ready, write_control,
        output pending_load_valid, pending_load_rd,
        output load_fault, retired_count
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results and loads into the register file,
// extracting/extending load data and tracking pending loads and retirements.
module writeback_unit
    import writeback_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 64
) (
    input logic              clock,
    input logic              reset,
    writeback_unit_if.slave  wb
);
    typedef enum logic {IDLE, WAIT_LOAD} state_e;

    state_e               state_q, state_d;
    reg_write_control_t   wc_q, wc_d;
    rv_reg_t              rd_q, rd_d;
    logic [2:0]           f3_q, f3_d;
    logic [1:0]           alo_q, alo_d;
    logic [7:0]           tmo_q, tmo_d;
    logic                 fault_q, fault_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic accept;
    logic legal_f3;

    function automatic logic [XLEN-1:0] extract(
        input logic [2:0]      f3,
        input logic [1:0]      lo,
        input logic [XLEN-1:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lo +: 8];
        h = w[16*lo[1] +: 16];
        unique case (1'b1)
            (f3 == 3'd0): extract = {{24{b[7]}}, b};
            (f3 == 3'd1): extract = {{16{h[15]}}, h};
            (f3 == 3'd4): extract = {24'd0, b};
            (f3 == 3'd5): extract = {16'd0, h};
            default:      extract = w;
        endcase
    endfunction

    assign accept   = wb.in_valid && (state_q == IDLE);
    assign legal_f3 = wb.in_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    always_comb begin
        state_d = state_q;
        wc_d    = '0;
        rd_d    = rd_q;
        f3_d    = f3_q;
        alo_d   = alo_q;
        tmo_d   = tmo_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (wb.in_kind)
                        K_ALU: begin
                            wc_d.enable         = (wb.in_rd != '0);
                            wc_d.which_register = wb.in_rd;
                            wc_d.value          = wb.in_alu_value;
                            cnt_d               = cnt_q + CNT_WIDTH'(1);
                        end
                        K_LOAD: begin
                            if (legal_f3) begin
                                rd_d    = wb.in_rd;
                                f3_d    = wb.in_funct3;
                                alo_d   = wb.in_addr_lo;
                                tmo_d   = '0;
                                state_d = WAIT_LOAD;
                            end else begin
                                fault_d = 1'b1;
                                cnt_d   = cnt_q + CNT_WIDTH'(1);
                            end
                        end
                        default: cnt_d = cnt_q + CNT_WIDTH'(1);
                    endcase
                end
            end
            WAIT_LOAD: begin
                // A response always beats the timeout in the same cycle.
                if (wb.mem_rdata_valid) begin
                    wc_d.enable         = (rd_q != '0);
                    wc_d.which_register = rd_q;
                    wc_d.value          = extract(f3_q, alo_q, wb.mem_rdata);
                    cnt_d               = cnt_q + CNT_WIDTH'(1);
                    tmo_d               = '0;
                    state_d             = IDLE;
                end else if (tmo_q == 8'(LOAD_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wc_q    <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            alo_q   <= '0;
            tmo_q   <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            alo_q   <= alo_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb.in_ready           = (state_q == IDLE);
    assign wb.pending_load_valid = (state_q == WAIT_LOAD);
    assign wb.pending_load_rd    = (state_q == WAIT_LOAD) ? rd_q : '0;
    assign wb.write_control      = wc_q;
    assign wb.load_fault         = fault_q;
    assign wb.retired_count      = cnt_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with LOAD_TIMEOUT=4.
module tb_writeback_unit;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    writeback_unit_if #(.CNT_WIDTH(64)) wb ();

    writeback_unit #(
        .LOAD_TIMEOUT(4),
        .CNT_WIDTH(64)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .wb(wb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3,
                        input logic [1:0] lo);
        wb.in_valid   = 1'b1;
        wb.in_kind    = 2'd2;
        wb.in_rd      = rd;
        wb.in_funct3  = f3;
        wb.in_addr_lo = lo;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] v);
        wb.in_valid     = 1'b1;
        wb.in_kind      = 2'd1;
        wb.in_rd        = rd;
        wb.in_alu_value = v;
    endtask

    task automatic resp(input logic [31:0] d);
        wb.mem_rdata_valid = 1'b1;
        wb.mem_rdata       = d;
    endtask

    task automatic quiet();
        wb.in_valid        = 1'b0;
        wb.mem_rdata_valid = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        wb.in_kind      = '0;
        wb.in_rd        = '0;
        wb.in_alu_value = '0;
        wb.in_funct3    = '0;
        wb.in_addr_lo   = '0;
        wb.mem_rdata    = '0;
        quiet();
        tick();
        tick();
        chk("rst_wc", 64'(wb.write_control), 64'd0);
        chk("rst_pend", 64'(wb.pending_load_valid), 64'd0);
        chk("rst_fault", 64'(wb.load_fault), 64'd0);
        chk("rst_cnt", wb.retired_count, 64'd0);
        chk("rst_ready", 64'(wb.in_ready), 64'd1);
        rst_n = 1'b1;

        // Back-to-back ALU retirements
        alu(5'd5, 32'h11);
        tick();
        chk("alu_x5", 64'(wb.write_control), 64'({1'b1, 5'd5, 32'h11}));
        alu(5'd6, 32'h22);
        tick();
        chk("alu_x6", 64'(wb.write_control), 64'({1'b1, 5'd6, 32'h22}));
        alu(5'd0, 32'h33);
        tick();
        chk("alu_x0", 64'(wb.write_control), 64'({1'b0, 5'd0, 32'h33}));
        quiet();
        tick();
        chk("alu_idle_en", 64'(wb.write_control.enable), 64'd0);
        chk("alu_cnt", wb.retired_count, 64'd3);

        // LB x7 at byte 3, response in the third wait cycle
        load(5'd7, 3'd0, 2'd3);
        tick();
        quiet();
        chk("lb_ready_w1", 64'(wb.in_ready), 64'd0);
        chk("lb_pend_v", 64'(wb.pending_load_valid), 64'd1);
        chk("lb_pend_rd", 64'(wb.pending_load_rd), 64'd7);
        tick();
        chk("lb_ready_w2", 64'(wb.in_ready), 64'd0);
        tick();
        chk("lb_ready_w3", 64'(wb.in_ready), 64'd0);
        chk("lb_no_wr", 64'(wb.write_control.enable), 64'd0);
        resp(32'h80FF_1234);
        tick();
        quiet();
        chk("lb_x7", 64'(wb.write_control),
            64'({1'b1, 5'd7, 32'hFFFF_FF80}));
        chk("lb_ready", 64'(wb.in_ready), 64'd1);
        chk("lb_pend_clr", 64'(wb.pending_load_rd), 64'd0);
        chk("lb_cnt", wb.retired_count, 64'd4);

        // LHU x8 upper half, LH x9 lower half; 1-cycle latency
        load(5'd8, 3'd5, 2'd2);
        tick();
        quiet();
        resp(32'h8001_F00F);
        tick();
        quiet();
        chk("lhu_x8", 64'(wb.write_control),
            64'({1'b1, 5'd8, 32'h0000_8001}));
        load(5'd9, 3'd1, 2'd0);
        tick();
        quiet();
        resp(32'h8001_F00F);
        tick();
        quiet();
        chk("lh_x9", 64'(wb.write_control),
            64'({1'b1, 5'd9, 32'hFFFF_F00F}));
        chk("lh_cnt", wb.retired_count, 64'd6);

        // LW with response exactly at the timeout limit, fault still clear
        load(5'd14, 3'd2, 2'd1);
        tick();
        quiet();
        tick();
        tick();
        tick();
        chk("race_pend", 64'(wb.pending_load_valid), 64'd1);
        resp(32'h1357_9BDF);
        tick();
        quiet();
        chk("race_wr", 64'(wb.write_control),
            64'({1'b1, 5'd14, 32'h1357_9BDF}));
        chk("race_fault", 64'(wb.load_fault), 64'd0);
        chk("race_cnt", wb.retired_count, 64'd7);

        // Asynchronous reset while waiting on a load
        load(5'd13, 3'd2, 2'd0);
        tick();
        quiet();
        chk("rw_pend", 64'(wb.pending_load_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_pend_v", 64'(wb.pending_load_valid), 64'd0);
        chk("rw_pend_rd", 64'(wb.pending_load_rd), 64'd0);
        chk("rw_ready", 64'(wb.in_ready), 64'd1);
        chk("rw_cnt", wb.retired_count, 64'd0);
        chk("rw_wc", 64'(wb.write_control), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        resp(32'hDEAD_BEEF);
        tick();
        quiet();
        chk("rw_late", 64'(wb.write_control.enable), 64'd0);
        chk("rw_late_cnt", wb.retired_count, 64'd0);

        // Illegal funct3, reserved kind, stray response in IDLE
        load(5'd12, 3'd3, 2'd0);
        tick();
        quiet();
        chk("ill_wr", 64'(wb.write_control.enable), 64'd0);
        chk("ill_fault", 64'(wb.load_fault), 64'd1);
        chk("ill_cnt", wb.retired_count, 64'd1);
        chk("ill_ready", 64'(wb.in_ready), 64'd1);
        wb.in_valid = 1'b1;
        wb.in_kind  = 2'd3;
        wb.in_rd    = 5'd3;
        tick();
        quiet();
        chk("rsv_wr", 64'(wb.write_control.enable), 64'd0);
        chk("rsv_cnt", wb.retired_count, 64'd2);
        resp(32'h0BAD_F00D);
        tick();
        quiet();
        chk("stray_wr", 64'(wb.write_control.enable), 64'd0);
        chk("stray_cnt", wb.retired_count, 64'd2);
        chk("stray_pend", 64'(wb.pending_load_valid), 64'd0);

        // Timeout after four silent wait cycles
        load(5'd10, 3'd2, 2'd0);
        tick();
        quiet();
        tick();
        tick();
        tick();
        chk("to_w4_pend", 64'(wb.pending_load_valid), 64'd1);
        chk("to_w4_rd", 64'(wb.pending_load_rd), 64'd10);
        tick();
        chk("to_fault", 64'(wb.load_fault), 64'd1);
        chk("to_wr", 64'(wb.write_control.enable), 64'd0);
        chk("to_ready", 64'(wb.in_ready), 64'd1);
        chk("to_cnt", wb.retired_count, 64'd2);

        // Second load answered at the limit still writes back
        load(5'd11, 3'd2, 2'd3);
        tick();
        quiet();
        tick();
        tick();
        tick();
        resp(32'hCAFE_BABE);
        tick();
        quiet();
        chk("lim_wr", 64'(wb.write_control),
            64'({1'b1, 5'd11, 32'hCAFE_BABE}));
        chk("lim_fault", 64'(wb.load_fault), 64'd1);
        chk("lim_cnt", wb.retired_count, 64'd3);
        tick();
        chk("lim_pulse", 64'(wb.write_control.enable), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage feeding the register file write port; it produces the reg_write_control_t that the register file consumes.
- Accepts retiring instructions from the memory stage (valid/ready), waits on data-memory responses for loads, and performs load byte/halfword extraction with sign/zero extension.
- Publishes a pending-load indication for hazard/stall logic and keeps a retired-instruction counter.

Parameters:
- LOAD_TIMEOUT, 16: cycles WAIT_LOAD tolerates without mem_rdata_valid before aborting (range 1..255).
- CNT_WIDTH, 64: width of retired-instruction counter.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  unit can accept; high iff state==IDLE.
- in_kind  in  2  0=NONE (no rd write), 1=ALU (value in in_alu_value), 2=LOAD, 3=reserved (treated as NONE).
- in_rd  in  5  rv_reg_t destination register.
- in_alu_value  in  XLEN  result for ALU kind.
- in_funct3  in  3  load width/sign: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- in_addr_lo  in  2  low address bits of load.
- mem_rdata_valid  in  1  data-memory response strobe.
- mem_rdata  in  XLEN  aligned 32-bit memory word.
- write_control  out  38  reg_write_control_t {enable, which_register, value} to register file.
- pending_load_valid  out  1  a load is in WAIT_LOAD.
- pending_load_rd  out  5  its rd (0 when not pending).
- load_fault  out  1  sticky: illegal funct3 or timeout.
- retired_count  out  CNT_WIDTH  instructions retired.

Behaviour:
- Reset (reset==0, async): state=IDLE, write_control all zero, pending outputs 0, load_fault 0, retired_count 0, timeout counter 0.
- States: IDLE, WAIT_LOAD.
- Accept = in_valid && in_ready. A registered write_control.enable/which_register/value is a one-cycle pulse; write_control.enable=0 in every other cycle.
- IDLE, accept ALU: next cycle enable=(in_rd!=0), which_register=in_rd, value=in_alu_value; retired_count+1 in that cycle. Stay IDLE (back-to-back accepts every cycle allowed).
- IDLE, accept NONE/reserved: no write, retired_count+1 next cycle.
- IDLE, accept LOAD with funct3 in {0,1,2,4,5}: latch rd/funct3/addr_lo, go WAIT_LOAD, timeout counter=0; pending_load_valid=1, pending_load_rd=rd from the next cycle.
- IDLE, accept LOAD with illegal funct3 (3,6,7): no write, load_fault set, retired_count+1, stay IDLE.
- mem_rdata_valid in IDLE is ignored.
- WAIT_LOAD: in_ready=0. On mem_rdata_valid: next cycle enable=(rd!=0), value=extracted data, retired_count+1, state=IDLE, pending cleared. A response in the first WAIT_LOAD cycle is valid (minimum load latency is 1 cycle after accept).
- Extraction: byte = mem_rdata[8*addr_lo +: 8]; halfword = mem_rdata[16*addr_lo[1] +: 16] (addr_lo[0] ignored); LB/LH sign-extend, LBU/LHU zero-extend, LW full word (addr_lo ignored).
- Timeout: the counter increments each WAIT_LOAD cycle without a response. When it reaches LOAD_TIMEOUT: load_fault set, no write, no retire, return to IDLE. A response in the same cycle the limit is reached wins: normal writeback, no fault.
- x0: never enabled; which_register/value are still driven for debug.
- load_fault is cleared only by reset. retired_count wraps modulo 2^CNT_WIDTH.
- Reset mid-WAIT_LOAD: immediate abort, no write; a late mem_rdata_valid is then ignored.

Test Plan:
- ALU accepts on 3 consecutive cycles (x5=0x11, x6=0x22, x0=0x33) -> enables 1,1,0 on the following cycles; values 0x11,0x22; retired_count=3.
- LB x7, addr_lo=3, response after 2 cycles, mem_rdata=0x80FF_1234 -> x7=0xFFFF_FF80; in_ready low for 3 cycles; pending_load_rd=7 during the wait.
- LHU x8 addr_lo=2 and LH x9 addr_lo=0 with mem_rdata=0x8001_F00F -> x8=0x0000_8001, x9=0xFFFF_F00F.
- LOAD_TIMEOUT=4, no response -> after 4 WAIT_LOAD cycles: load_fault=1, no write, back to IDLE, retired_count unchanged; then a response arriving exactly at the limit in a second load -> write occurs, fault unchanged.
- LOAD funct3=3 -> no write, load_fault=1, retired_count+1; a stray mem_rdata_valid in IDLE -> no effect.
- Assert reset low asynchronously mid-WAIT_LOAD -> outputs zero immediately; a later mem_rdata_valid produces no write.
